// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding, fetch FSM states and default widths.
package cpu_pkg;

    localparam int unsigned CPU_DATA_W = 16;
    localparam int unsigned CPU_PC_W   = 10;
    localparam int unsigned OP_W       = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_LDM  = 3'b100,
        OP_IADD = 3'b101,
        OP_JMP  = 3'b110,
        OP_HLT  = 3'b111
    } opcode_e;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_IMM   = 1'b1
    } state_e;

    // Opcodes whose word is followed by a 16-bit immediate word.
    function automatic logic is_imm_op(input logic [OP_W-1:0] op);
        return (op == OP_LDM) || (op == OP_IADD);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, pipeline control and IF/ID outputs.
interface fetch_stage_if
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned PC_W   = CPU_PC_W
);
    logic [PC_W-1:0]   imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              stall;
    logic              redirect_en;
    logic [PC_W-1:0]   redirect_pc;
    logic [DATA_W-1:0] if_instr;
    logic [DATA_W-1:0] if_imm;
    logic [PC_W-1:0]   if_pc;
    logic              if_valid;
    logic [OP_W-1:0]   if_opcode;

    modport master (
        output imem_addr, if_instr, if_imm, if_pc, if_valid, if_opcode,
        input  imem_rdata, stall, redirect_en, redirect_pc
    );

    modport slave (
        input  imem_addr, if_instr, if_imm, if_pc, if_valid, if_opcode,
        output imem_rdata, stall, redirect_en, redirect_pc
    );
endinterface

// File: rtl/pc_reg.sv
// Program counter: reset > redirect > stall > increment (wraps modulo 2^PC_W).
module pc_reg #(
    parameter int unsigned    PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_en_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    input  logic            stall_i,
    output logic [PC_W-1:0] pc_o
);
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_en_i) begin
            pc_d = redirect_pc_i;
        end else if (!stall_i) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID register; assembles opcode+immediate word pairs.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = CPU_DATA_W,
    parameter int unsigned PC_W     = CPU_PC_W,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] word_c;
    logic [OP_W-1:0]   word_op_c;
    logic [OP_W-1:0]   hold_op_c;

    state_e            state_q;
    logic [DATA_W-1:0] hold_q;
    logic [PC_W-1:0]   hold_pc_q;
    logic [DATA_W-1:0] if_instr_q;
    logic [DATA_W-1:0] if_imm_q;
    logic [PC_W-1:0]   if_pc_q;
    logic              if_valid_q;
    logic [OP_W-1:0]   if_opcode_q;

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (PC_W'(RESET_PC))
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .redirect_en_i (bus.redirect_en),
        .redirect_pc_i (bus.redirect_pc),
        .stall_i       (bus.stall),
        .pc_o          (pc)
    );

    assign word_c    = bus.imem_rdata;
    assign word_op_c = word_c[DATA_W-1 -: OP_W];
    assign hold_op_c = hold_q[DATA_W-1 -: OP_W];

    // Fetch FSM and IF/ID register; a redirect squashes any half-built pair.
    always_ff @(posedge clk) begin
        if (rst || bus.redirect_en) begin
            state_q     <= S_FETCH;
            hold_q      <= '0;
            hold_pc_q   <= '0;
            if_instr_q  <= '0;
            if_imm_q    <= '0;
            if_pc_q     <= '0;
            if_valid_q  <= 1'b0;
            if_opcode_q <= OP_NOP;
        end else if (!bus.stall) begin
            case (state_q)
                S_FETCH: begin
                    if (is_imm_op(word_op_c)) begin
                        hold_q      <= word_c;
                        hold_pc_q   <= pc;
                        state_q     <= S_IMM;
                        if_instr_q  <= '0;
                        if_imm_q    <= '0;
                        if_pc_q     <= '0;
                        if_valid_q  <= 1'b0;
                        if_opcode_q <= OP_NOP;
                    end else begin
                        if_instr_q  <= word_c;
                        if_imm_q    <= '0;
                        if_pc_q     <= pc;
                        if_valid_q  <= 1'b1;
                        if_opcode_q <= word_op_c;
                    end
                end
                S_IMM: begin
                    if_instr_q  <= hold_q;
                    if_imm_q    <= word_c;
                    if_pc_q     <= hold_pc_q;
                    if_valid_q  <= 1'b1;
                    if_opcode_q <= hold_op_c;
                    state_q     <= S_FETCH;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign bus.imem_addr = pc;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_imm    = if_imm_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_opcode = if_opcode_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural instruction memory.
module tb_fetch_stage;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [15:0] imem [0:1023];

    fetch_stage_if #(.DATA_W(16), .PC_W(10)) bus ();

    fetch_stage #(.DATA_W(16), .PC_W(10), .RESET_PC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.imem_rdata = imem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input logic [15:0] v);
        for (int i = 0; i < 1024; i++) imem[i] = v;
    endtask

    task automatic cold_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        fill_mem(16'hE5A5);
        rst = 1'b1;
        step();
        step();
        checks++; if (bus.imem_addr !== 10'h000) begin errors++; $display("FAIL reset_addr got %h exp %h", bus.imem_addr, 10'h000); end
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.if_valid); end
        checks++; if (bus.if_opcode !== 3'b000) begin errors++; $display("FAIL reset_opcode got %b exp 000", bus.if_opcode); end
        checks++; if (bus.if_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h exp 0000", bus.if_instr); end
        checks++; if (bus.if_imm !== 16'h0000) begin errors++; $display("FAIL reset_imm got %h exp 0000", bus.if_imm); end
        rst = 1'b0;
    endtask

    task automatic test_straight_line();
        logic [15:0] words [0:2];
        logic [2:0]  ops   [0:2];
        words[0] = 16'h2001; words[1] = 16'h4002; words[2] = 16'h6003;
        ops[0] = 3'b001; ops[1] = 3'b010; ops[2] = 3'b011;
        fill_mem(16'h0000);
        for (int i = 0; i < 3; i++) imem[i] = words[i];
        cold_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.if_opcode !== ops[i]) begin errors++; $display("FAIL line_opcode[%0d] got %b exp %b", i, bus.if_opcode, ops[i]); end
            checks++; if (bus.if_instr !== words[i]) begin errors++; $display("FAIL line_instr[%0d] got %h exp %h", i, bus.if_instr, words[i]); end
            checks++; if (bus.if_pc !== 10'(i)) begin errors++; $display("FAIL line_pc[%0d] got %h exp %h", i, bus.if_pc, 10'(i)); end
            checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL line_valid[%0d] got %b exp 1", i, bus.if_valid); end
            checks++; if (bus.if_imm !== 16'h0000) begin errors++; $display("FAIL line_imm[%0d] got %h exp 0000", i, bus.if_imm); end
        end
        checks++; if (bus.imem_addr !== 10'h003) begin errors++; $display("FAIL line_addr got %h exp 003", bus.imem_addr); end
    endtask

    task automatic test_imm_pair();
        fill_mem(16'h0000);
        imem[0] = 16'h8005; imem[1] = 16'h1234; imem[2] = 16'h2007;
        cold_reset();
        step();
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL pair_bubble_valid got %b exp 0", bus.if_valid); end
        checks++; if (bus.if_opcode !== 3'b000) begin errors++; $display("FAIL pair_bubble_opcode got %b exp 000", bus.if_opcode); end
        checks++; if (bus.imem_addr !== 10'h001) begin errors++; $display("FAIL pair_addr1 got %h exp 001", bus.imem_addr); end
        step();
        checks++; if (bus.if_instr !== 16'h8005) begin errors++; $display("FAIL pair_instr got %h exp 8005", bus.if_instr); end
        checks++; if (bus.if_imm !== 16'h1234) begin errors++; $display("FAIL pair_imm got %h exp 1234", bus.if_imm); end
        checks++; if (bus.if_pc !== 10'h000) begin errors++; $display("FAIL pair_pc got %h exp 000", bus.if_pc); end
        checks++; if (bus.if_opcode !== 3'b100) begin errors++; $display("FAIL pair_opcode got %b exp 100", bus.if_opcode); end
        checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL pair_valid got %b exp 1", bus.if_valid); end
        checks++; if (bus.imem_addr !== 10'h002) begin errors++; $display("FAIL pair_addr2 got %h exp 002", bus.imem_addr); end
        step();
        checks++; if (bus.if_instr !== 16'h2007 || bus.if_imm !== 16'h0000 || bus.if_pc !== 10'h002) begin
            errors++; $display("FAIL pair_next got instr %h imm %h pc %h exp 2007 0000 002", bus.if_instr, bus.if_imm, bus.if_pc);
        end
    endtask

    task automatic test_stall();
        fill_mem(16'h0000);
        imem[0] = 16'h2001; imem[1] = 16'h4002; imem[2] = 16'h6003; imem[3] = 16'h2004;
        cold_reset();
        step();
        step();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.if_instr !== 16'h4002 || bus.if_pc !== 10'h001 || bus.if_valid !== 1'b1 || bus.if_opcode !== 3'b010) begin
                errors++; $display("FAIL stall_hold[%0d] got instr %h pc %h valid %b op %b exp 4002 001 1 010", i, bus.if_instr, bus.if_pc, bus.if_valid, bus.if_opcode);
            end
            checks++; if (bus.imem_addr !== 10'h002) begin errors++; $display("FAIL stall_addr[%0d] got %h exp 002", i, bus.imem_addr); end
        end
        bus.stall = 1'b0;
        step();
        checks++; if (bus.if_instr !== 16'h6003 || bus.if_pc !== 10'h002) begin errors++; $display("FAIL stall_resume0 got %h pc %h exp 6003 002", bus.if_instr, bus.if_pc); end
        step();
        checks++; if (bus.if_instr !== 16'h2004 || bus.if_pc !== 10'h003) begin errors++; $display("FAIL stall_resume1 got %h pc %h exp 2004 003", bus.if_instr, bus.if_pc); end
    endtask

    task automatic test_redirect_mid_pair();
        fill_mem(16'h0000);
        imem[0] = 16'h8005; imem[1] = 16'h1234; imem[10'h040] = 16'h6003; imem[10'h041] = 16'h2001;
        cold_reset();
        step();
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 10'h040;
        step();
        bus.redirect_en = 1'b0;
        checks++; if (bus.if_valid !== 1'b0 || bus.if_instr !== 16'h0000 || bus.if_opcode !== 3'b000) begin
            errors++; $display("FAIL redir_squash got valid %b instr %h op %b exp 0 0000 000", bus.if_valid, bus.if_instr, bus.if_opcode);
        end
        checks++; if (bus.imem_addr !== 10'h040) begin errors++; $display("FAIL redir_addr got %h exp 040", bus.imem_addr); end
        step();
        checks++; if (bus.if_instr !== 16'h6003 || bus.if_pc !== 10'h040 || bus.if_valid !== 1'b1) begin
            errors++; $display("FAIL redir_target got instr %h pc %h valid %b exp 6003 040 1", bus.if_instr, bus.if_pc, bus.if_valid);
        end
        step();
        checks++; if (bus.if_instr !== 16'h2001 || bus.if_imm !== 16'h0000) begin errors++; $display("FAIL redir_next got %h imm %h exp 2001 0000", bus.if_instr, bus.if_imm); end
    endtask

    task automatic test_wrap_priority();
        fill_mem(16'h0000);
        imem[10'h3FF] = 16'hA000; imem[0] = 16'h00FF; imem[1] = 16'h2001; imem[10'h100] = 16'h6003;
        cold_reset();
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 10'h3FF;
        step();
        bus.redirect_en = 1'b0;
        step();
        checks++; if (bus.imem_addr !== 10'h000 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL wrap_mid got addr %h valid %b exp 000 0", bus.imem_addr, bus.if_valid); end
        step();
        checks++; if (bus.if_instr !== 16'hA000 || bus.if_imm !== 16'h00FF || bus.if_pc !== 10'h3FF || bus.if_opcode !== 3'b101) begin
            errors++; $display("FAIL wrap_pair got instr %h imm %h pc %h op %b exp A000 00FF 3FF 101", bus.if_instr, bus.if_imm, bus.if_pc, bus.if_opcode);
        end
        checks++; if (bus.imem_addr !== 10'h001) begin errors++; $display("FAIL wrap_addr got %h exp 001", bus.imem_addr); end
        bus.stall = 1'b1;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 10'h100;
        step();
        bus.stall = 1'b0;
        bus.redirect_en = 1'b0;
        checks++; if (bus.imem_addr !== 10'h100 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL prio_redirect got addr %h valid %b exp 100 0", bus.imem_addr, bus.if_valid); end
        step();
        checks++; if (bus.if_instr !== 16'h6003 || bus.if_pc !== 10'h100) begin errors++; $display("FAIL prio_target got %h pc %h exp 6003 100", bus.if_instr, bus.if_pc); end
    endtask

    task automatic test_reset_mid_pair();
        fill_mem(16'h0000);
        imem[0] = 16'h8005; imem[1] = 16'h1234; imem[2] = 16'h4002; imem[3] = 16'h5678;
        cold_reset();
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.imem_addr !== 10'h000 || bus.if_valid !== 1'b0 || bus.if_instr !== 16'h0000) begin
            errors++; $display("FAIL rstmid got addr %h valid %b instr %h exp 000 0 0000", bus.imem_addr, bus.if_valid, bus.if_instr);
        end
        step();
        step();
        checks++; if (bus.if_instr !== 16'h8005 || bus.if_imm !== 16'h1234 || bus.if_pc !== 10'h000) begin
            errors++; $display("FAIL rstmid_pair got instr %h imm %h pc %h exp 8005 1234 000", bus.if_instr, bus.if_imm, bus.if_pc);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 10'h000;
        test_reset();
        test_straight_line();
        test_imm_pair();
        test_stall();
        test_redirect_mid_pair();
        test_wrap_priority();
        test_reset_mid_pair();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
